// File: rtl/change_dispenser.sv
// ============================================================================
// Module   : change_dispenser
// Brief    : Greedy coin payout FSM with per-denomination refillable inventory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module change_dispenser #(
  parameter int AMT_W      = 9,
  parameter int INV_W      = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  output logic             busy,
  output logic [2:0]       coin_code,
  output logic             coin_valid,
  input  logic             coin_ready,
  output logic             done,
  output logic             short_change,
  output logic [AMT_W-1:0] remaining,
  input  logic             refill_en,
  input  logic [2:0]       refill_code,
  input  logic [INV_W-1:0] refill_count
);

  localparam int         C_NUM_DENOM = 5;
  localparam [INV_W-1:0] C_INIT_INV  = INV_W'(INIT_COUNT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [INV_W-1:0] r_inv [C_NUM_DENOM];

  logic             w_sel_found;
  logic [2:0]       w_sel_code;
  logic [INV_W-1:0] w_refill_cur;
  logic [INV_W:0]   w_refill_full;
  logic [INV_W-1:0] w_refill_sat;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] code);
    case (code)
      3'd1:    coin_value = AMT_W'(5);
      3'd2:    coin_value = AMT_W'(10);
      3'd3:    coin_value = AMT_W'(25);
      3'd4:    coin_value = AMT_W'(50);
      3'd5:    coin_value = AMT_W'(100);
      default: coin_value = '0;
    endcase
  endfunction

  // Scanning from the smallest upward lets the largest qualifying coin win.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_code  = 3'd0;
    for (int i = 0; i < C_NUM_DENOM; i++) begin
      if (r_inv[i] != '0 && coin_value(3'(i + 1)) <= remaining) begin
        w_sel_found = 1'b1;
        w_sel_code  = 3'(i + 1);
      end
    end
  end

  always_comb begin
    w_refill_cur = '0;
    for (int i = 0; i < C_NUM_DENOM; i++) begin
      if (refill_code == 3'(i + 1)) w_refill_cur = r_inv[i];
    end
    w_refill_full = {1'b0, w_refill_cur} + {1'b0, refill_count};
    w_refill_sat  = w_refill_full[INV_W] ? '1 : w_refill_full[INV_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      coin_code    <= 3'd0;
      coin_valid   <= 1'b0;
      done         <= 1'b0;
      short_change <= 1'b0;
      remaining    <= '0;
      for (int i = 0; i < C_NUM_DENOM; i++) r_inv[i] <= C_INIT_INV;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            remaining    <= change_amount;
            short_change <= 1'b0;
            busy         <= 1'b1;
            r_state      <= S_SELECT;
          end else if (refill_en) begin
            for (int i = 0; i < C_NUM_DENOM; i++) begin
              if (refill_code == 3'(i + 1)) r_inv[i] <= w_refill_sat;
            end
          end
        end
        S_SELECT: begin
          if (remaining != '0 && w_sel_found) begin
            coin_code  <= w_sel_code;
            coin_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            short_change <= (remaining != '0);
            done         <= 1'b1;
            busy         <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (coin_ready) begin
            for (int i = 0; i < C_NUM_DENOM; i++) begin
              if (coin_code == 3'(i + 1)) r_inv[i] <= r_inv[i] - INV_W'(1);
            end
            remaining  <= remaining - coin_value(coin_code);
            coin_valid <= 1'b0;
            r_state    <= S_SELECT;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module   : tb_change_dispenser
// Brief    : Self-checking bench: vector table, corner sequences, random payouts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  localparam int AMT_W = 9;
  localparam int INV_W = 8;
  localparam int INIT  = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [AMT_W-1:0] change_amount = '0;
  logic             busy;
  logic [2:0]       coin_code;
  logic             coin_valid;
  logic             coin_ready = 1'b0;
  logic             done;
  logic             short_change;
  logic [AMT_W-1:0] remaining;
  logic             refill_en = 1'b0;
  logic [2:0]       refill_code = 3'd0;
  logic [INV_W-1:0] refill_count = '0;

  change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INIT_COUNT(INIT)) dut (
    .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
    .busy(busy), .coin_code(coin_code), .coin_valid(coin_valid),
    .coin_ready(coin_ready), .done(done), .short_change(short_change),
    .remaining(remaining), .refill_en(refill_en), .refill_code(refill_code),
    .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int model_inv [5];

  logic [2:0] got [$];
  int  cyc;
  bit  saw_done, stable_ok, busy_ok, any_valid;

  int  exp_coins [$];
  int  exp_rem;
  bit  exp_sh;

  typedef struct {
    int          amt;
    int          n;
    logic [23:0] coins;   // first coin in the lowest octal digit
    int          rem;
    bit          sh;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int value_of(input int code);
    int vals [6] = '{0, 5, 10, 25, 50, 100};
    return (code >= 1 && code <= 5) ? vals[code] : 0;
  endfunction

  // Greedy payout computed directly from denomination values and stock.
  task automatic model_payout(input int amt);
    bit progress;
    exp_coins.delete();
    exp_rem = amt;
    exp_sh  = 1'b0;
    progress = 1'b1;
    while (exp_rem > 0 && progress) begin
      progress = 1'b0;
      for (int c = 5; c >= 1 && !progress; c--) begin
        if (value_of(c) <= exp_rem && model_inv[c-1] > 0) begin
          exp_coins.push_back(c);
          model_inv[c-1]--;
          exp_rem -= value_of(c);
          progress = 1'b1;
        end
      end
    end
    if (exp_rem > 0) exp_sh = 1'b1;
  endtask

  task automatic model_refill(input int code, input int cnt);
    if (code >= 1 && code <= 5) begin
      model_inv[code-1] += cnt;
      if (model_inv[code-1] > 255) model_inv[code-1] = 255;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) model_inv[i] = INIT;
  endtask

  task automatic do_refill(input int code, input int cnt);
    refill_en = 1'b1; refill_code = 3'(code); refill_count = 8'(cnt);
    @(posedge clk); #1;
    refill_en = 1'b0;
    model_refill(code, cnt);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready held low for the first 5 valid cycles
  task automatic do_payout(input int amt, input int mode, input bit poke, input bit refill_at_start);
    logic [2:0] held;
    bit hold_pending;
    int low_left;
    held = 3'd0; hold_pending = 1'b0; low_left = 5;
    got.delete();
    saw_done = 1'b0; stable_ok = 1'b1; busy_ok = 1'b1; any_valid = 1'b0;
    start = 1'b1; change_amount = AMT_W'(amt);
    if (refill_at_start) begin refill_en = 1'b1; refill_code = 3'd1; refill_count = 8'd50; end
    @(posedge clk); #1;
    start = 1'b0; refill_en = 1'b0; cyc = 1;
    while (cyc < 4000) begin
      if (done) begin saw_done = 1'b1; break; end
      if (!busy) busy_ok = 1'b0;
      if (coin_valid) any_valid = 1'b1;
      if (hold_pending && !(coin_valid && coin_code == held)) stable_ok = 1'b0;
      if (poke) begin
        start = (cyc >= 2 && cyc <= 4);
        refill_en = start; refill_code = 3'd3; refill_count = 8'd77;
        change_amount = AMT_W'(5);
      end
      case (mode)
        0: coin_ready = 1'b1;
        1: coin_ready = 1'($urandom_range(0, 1));
        default: begin
          coin_ready = coin_valid && (low_left == 0);
          if (coin_valid && low_left > 0) low_left--;
        end
      endcase
      hold_pending = coin_valid && !coin_ready;
      held = coin_code;
      if (coin_valid && coin_ready) got.push_back(coin_code);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; refill_en = 1'b0; coin_ready = 1'b0;
  endtask

  task automatic finish_payout(input string nm, input int mode);
    check({nm, " done_seen"}, 32'(saw_done), 32'd1);
    check({nm, " busy_during"}, 32'(busy_ok), 32'd1);
    check({nm, " busy_at_done"}, 32'(busy), 32'd0);
    check({nm, " coin_stable"}, 32'(stable_ok), 32'd1);
    check({nm, " n_coins"}, 32'(got.size()), 32'(exp_coins.size()));
    for (int k = 0; k < exp_coins.size() && k < got.size(); k++)
      check({nm, " coin"}, 32'(got[k]), 32'(exp_coins[k]));
    if (exp_coins.size() == 0) check({nm, " no_valid"}, 32'(any_valid), 32'd0);
    check({nm, " remaining"}, 32'(remaining), 32'(exp_rem));
    check({nm, " short"}, 32'(short_change), 32'(exp_sh));
    if (mode == 0) check({nm, " latency"}, 32'(cyc), 32'(2 + 2 * exp_coins.size()));
    @(posedge clk); #1;
    check({nm, " done_pulse"}, 32'(done), 32'd0);
    for (int i = 0; i < 5; i++) check({nm, " inventory"}, 32'(dut.r_inv[i]), 32'(model_inv[i]));
  endtask

  task automatic verify_payout(input string nm, input int amt, input int mode, input bit poke,
                               input bit refill_at_start);
    model_payout(amt);
    do_payout(amt, mode, poke, refill_at_start);
    finish_payout(nm, mode);
  endtask

  initial begin
    tbl[0] = '{185, 4, 24'o2345,   0, 1'b0};
    tbl[1] = '{0,   0, 24'o0,      0, 1'b0};
    tbl[2] = '{7,   1, 24'o1,      2, 1'b1};
    tbl[3] = '{95,  4, 24'o2234,   0, 1'b0};
    tbl[4] = '{511, 6, 24'o255555, 1, 1'b1};
    tbl[5] = '{40,  3, 24'o123,    0, 1'b0};

    do_reset();
    check("reset coin_valid", 32'(coin_valid), 32'd0);
    check("reset coin_code", 32'(coin_code), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset short", 32'(short_change), 32'd0);
    check("reset remaining", 32'(remaining), 32'd0);

    foreach (tbl[t]) begin
      logic [23:0] cw;
      do_reset();
      model_payout(tbl[t].amt);
      do_payout(tbl[t].amt, 0, 1'b0, 1'b0);
      cw = tbl[t].coins;
      check("tbl done_seen", 32'(saw_done), 32'd1);
      check("tbl n_coins", 32'(got.size()), 32'(tbl[t].n));
      for (int k = 0; k < tbl[t].n && k < got.size(); k++)
        check("tbl coin", 32'(got[k]), 32'((cw >> (3 * k)) & 24'd7));
      check("tbl remaining", 32'(remaining), 32'(tbl[t].rem));
      check("tbl short", 32'(short_change), 32'(tbl[t].sh));
      check("tbl latency", 32'(cyc), 32'(2 + 2 * tbl[t].n));
      if (tbl[t].n == 0) check("tbl no_valid", 32'(any_valid), 32'd0);
      @(posedge clk); #1;
      check("tbl done_pulse", 32'(done), 32'd0);
      for (int i = 0; i < 5; i++) check("tbl inventory", 32'(dut.r_inv[i]), 32'(model_inv[i]));
    end

    // Drain nickels, then 30c with a same-cycle refill that must be ignored.
    do_reset();
    for (int n = 0; n < 10; n++) verify_payout("drain", 5, 0, 1'b0, 1'b0);
    verify_payout("no_nickel", 30, 0, 1'b0, 1'b1);
    check("no_nickel remaining", 32'(remaining), 32'd5);
    check("no_nickel short", 32'(short_change), 32'd1);
    check("no_nickel inv", 32'(dut.r_inv[0]), 32'd0);

    do_reset();
    verify_payout("backpressure", 60, 2, 1'b0, 1'b0);

    do_reset();
    do_refill(3, 250);
    check("refill saturate", 32'(dut.r_inv[2]), 32'd255);
    do_refill(6, 20);
    do_refill(0, 20);
    verify_payout("busy_poke", 185, 0, 1'b1, 1'b0);

    do_reset();
    start = 1'b1; change_amount = AMT_W'(185);
    @(posedge clk); #1;
    start = 1'b0; coin_ready = 1'b0;
    for (int w = 0; w < 20 && !coin_valid; w++) begin @(posedge clk); #1; end
    check("midreset valid_before", 32'(coin_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midreset coin_valid", 32'(coin_valid), 32'd0);
    check("midreset coin_code", 32'(coin_code), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset remaining", 32'(remaining), 32'd0);
    check("midreset short", 32'(short_change), 32'd0);
    for (int i = 0; i < 5; i++) check("midreset inventory", 32'(dut.r_inv[i]), 32'(INIT));
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) model_inv[i] = INIT;
    verify_payout("after_reset", 185, 0, 1'b0, 1'b0);

    do_reset();
    for (int r = 0; r < 40; r++) begin
      int nref;
      nref = int'($urandom_range(0, 2));
      for (int j = 0; j < nref; j++)
        do_refill(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      verify_payout("random", int'($urandom_range(0, 511)), 1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
